caf_peak_sched: RTL and testbench
=================================

// Module: caf_peak_sched
// PURPOSE
// - Sequences one argmax unit across freq_bins Doppler bins of a CAF search.
// - Per bin: selects bin (freq_idx), gates buffer_length correlator beats into argmax, waits for result.
// - Keeps the global peak (magnitude, time index, bin); one-cycle done pulse after last bin.
// - Sits between the frequency-shift/correlator front end and argmax; data bypasses it, only handshakes pass through.
// PARAMETERS
// - buffer_length  10  correlator samples per bin (= argmax buffer_length)
// - freq_bins      4   Doppler bins per search, >=1
// - freq_bits      2   width of bin index, 2**freq_bits >= freq_bins
// - index_bits     4   width of argmax index
// - out_max_bits   4   width of argmax magnitude
// - timeout_cycles 64  drain watchdog limit (used only with CAF_SCHED_TIMEOUT_EN)
// PORTS
// - clk          in   1             clock, all logic on rising edge
// - reset        in   1             synchronous, active-high
// - start        in   1             begin search; sampled only in IDLE
// - src_tvalid   in   1             correlator sample valid
// - src_tready   out  1             correlator ready = am_s_tready & (state==STREAM)
// - am_m_tvalid  out  1             to argmax m_axis_tvalid = src_tvalid & (state==STREAM)
// - am_s_tready  in   1             argmax s_axis_tready
// - am_m_tready  out  1             to argmax m_axis_tready; 1 in STREAM and DRAIN, else 0
// - am_s_tvalid  in   1             argmax result valid
// - am_out_max   in   out_max_bits  argmax peak magnitude
// - am_index     in   index_bits    argmax peak index
// - freq_idx     out  freq_bits     current bin to frequency shifter
// - peak_max     out  out_max_bits  global peak magnitude
// - peak_index   out  index_bits    time index of global peak
// - peak_freq    out  freq_bits     bin of global peak
// - busy         out  1             high in every state except IDLE
// - done         out  1             one-cycle pulse, results valid
// - error        out  1             watchdog abort flag (tied 0 without macro)
// BEHAVIOUR
// - Reset: state=IDLE; all outputs 0; sample count 0; reset mid-search aborts, no done.
// - States: IDLE, STREAM, DRAIN, FINISH.
// - IDLE: start=1 -> STREAM next cycle; freq_idx=0, peak_* cleared, error cleared. start elsewhere ignored.
// - STREAM: count beats where src_tvalid & src_tready; beat buffer_length -> DRAIN next cycle,
//   count cleared; no (buffer_length+1)th beat ever passed to argmax in this bin.
// - DRAIN: wait am_s_tvalid. On it: if am_out_max > peak_max (strict, unsigned) OR first bin,
//   load peak_max/peak_index/peak_freq=freq_idx; ties keep earlier bin.
//   freq_idx==freq_bins-1 -> FINISH; else freq_idx+1 -> STREAM same edge.
// - am_s_tvalid outside DRAIN ignored.
// - FINISH: done=1 for exactly one cycle, -> IDLE; peak_* held until next start.
// - Latency: one bin = buffer_length accepted beats + argmax drain + 1 cycle; done 1 cycle after last capture.
// - freq_idx changes only on DRAIN->STREAM edge or start; stable for whole bin.
// - No arithmetic growth: counter index_bits+1 wide, compares unsigned.
// CONFIGURATION
// - CAF_SCHED_TIMEOUT_EN defined: DRAIN cycles counted; reaching timeout_cycles without am_s_tvalid
//   -> error=1 (sticky until next start), -> IDLE, no done, peak_* hold partial result.
// - Undefined: no watchdog counter, DRAIN waits indefinitely, error tied 0.
// TESTING
// - Defaults, argmax model, peak 9 in bin 2 -> done once, peak_max=9, peak_freq=2, peak_index as reported.
// - Equal max 7 in bins 1 and 3 -> peak_freq=1 (tie keeps earlier).
// - src_tvalid toggled 50%, am_s_tready low 3 cycles mid-bin -> exactly 10 beats per bin, 40 total.
// - reset at beat 5 of bin 1 -> next cycle IDLE, busy=0, freq_idx=0, no done; restart completes normally.
// - start pulsed while busy -> ignored, single done at end of original search.
// - CAF_SCHED_TIMEOUT_EN, argmax never asserts valid -> error=1 after 64 DRAIN cycles, IDLE, no done.

Source files
------------

// File: rtl/caf_peak_sched.sv
// caf_peak_sched
//   Sequences a single argmax unit across freq_bins Doppler bins of a CAF
//   search and keeps the global peak (magnitude, time index, bin).
//   Correlator data bypasses this block; only handshakes are routed here.
//
//   Optional feature: define CAF_SCHED_TIMEOUT_EN to enable the DRAIN
//   watchdog. Without it, DRAIN waits indefinitely and error is tied 0.
//
// Ports
//   clk, reset         clock (rising edge), synchronous active-high reset
//   start              begin a search (sampled only while idle)
//   src_tvalid/tready  correlator sample handshake
//   am_m_tvalid        sample valid towards argmax input
//   am_s_tready        argmax input ready
//   am_m_tready        ready towards argmax result (STREAM and DRAIN)
//   am_s_tvalid        argmax result valid
//   am_out_max         argmax peak magnitude
//   am_index           argmax peak index
//   freq_idx           current bin to frequency shifter
//   peak_max           global peak magnitude
//   peak_index         time index of global peak
//   peak_freq          bin of global peak
//   busy               high whenever not idle
//   done               one-cycle pulse, peak_* valid
//   error              watchdog abort flag, sticky until next start
module caf_peak_sched #(
  parameter int unsigned buffer_length  = 10,
  parameter int unsigned freq_bins      = 4,
  parameter int unsigned freq_bits      = 2,
  parameter int unsigned index_bits     = 4,
  parameter int unsigned out_max_bits   = 4,
  parameter int unsigned timeout_cycles = 64
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    src_tvalid,
  output logic                    src_tready,
  output logic                    am_m_tvalid,
  input  logic                    am_s_tready,
  output logic                    am_m_tready,
  input  logic                    am_s_tvalid,
  input  logic [out_max_bits-1:0] am_out_max,
  input  logic [index_bits-1:0]   am_index,
  output logic [freq_bits-1:0]    freq_idx,
  output logic [out_max_bits-1:0] peak_max,
  output logic [index_bits-1:0]   peak_index,
  output logic [freq_bits-1:0]    peak_freq,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  if (freq_bins < 1 || freq_bins > (1 << freq_bits) || timeout_cycles < 1 ||
      buffer_length < 1) begin : g_param_check
    $error("caf_peak_sched: invalid parameter combination");
  end

  localparam int unsigned CNT_W = index_bits + 1;
  localparam logic [CNT_W-1:0]     LAST_BEAT = CNT_W'(buffer_length - 1);
  localparam logic [freq_bits-1:0] LAST_BIN  = freq_bits'(freq_bins - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DRAIN,
    S_FINISH
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [freq_bits-1:0]    freq_idx_q, freq_idx_d;
  logic [out_max_bits-1:0] peak_max_q, peak_max_d;
  logic [index_bits-1:0]   peak_index_q, peak_index_d;
  logic [freq_bits-1:0]    peak_freq_q, peak_freq_d;
  logic                    beat;

`ifdef CAF_SCHED_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(timeout_cycles + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(timeout_cycles - 1);

  logic            error_q, error_d;
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Handshakes are only opened towards argmax while streaming, so the
  // transition to DRAIN on the last beat blocks any further beat in the bin.
  assign src_tready  = am_s_tready & (state_q == S_STREAM);
  assign am_m_tvalid = src_tvalid & (state_q == S_STREAM);
  assign am_m_tready = (state_q == S_STREAM) | (state_q == S_DRAIN);
  assign beat        = src_tvalid & src_tready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    freq_idx_d   = freq_idx_q;
    peak_max_d   = peak_max_q;
    peak_index_d = peak_index_q;
    peak_freq_d  = peak_freq_q;
`ifdef CAF_SCHED_TIMEOUT_EN
    error_d      = error_q;
    wd_d         = '0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_STREAM;
          cnt_d        = '0;
          freq_idx_d   = '0;
          peak_max_d   = '0;
          peak_index_d = '0;
          peak_freq_d  = '0;
`ifdef CAF_SCHED_TIMEOUT_EN
          error_d      = 1'b0;
`endif
        end
      end
      S_STREAM: begin
        if (beat) begin
          if (cnt_q == LAST_BEAT) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (am_s_tvalid) begin
          // Strict compare keeps the earliest bin on ties; bin 0 always
          // loads so a search of all-zero magnitudes still reports bin 0.
          if ((am_out_max > peak_max_q) || (freq_idx_q == '0)) begin
            peak_max_d   = am_out_max;
            peak_index_d = am_index;
            peak_freq_d  = freq_idx_q;
          end
          if (freq_idx_q == LAST_BIN) begin
            state_d = S_FINISH;
          end else begin
            freq_idx_d = freq_idx_q + 1'b1;
            state_d    = S_STREAM;
          end
        end
`ifdef CAF_SCHED_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          error_d = 1'b1;
          state_d = S_IDLE;
        end else begin
          wd_d = wd_q + 1'b1;
        end
`endif
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      freq_idx_q   <= '0;
      peak_max_q   <= '0;
      peak_index_q <= '0;
      peak_freq_q  <= '0;
`ifdef CAF_SCHED_TIMEOUT_EN
      error_q      <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      freq_idx_q   <= freq_idx_d;
      peak_max_q   <= peak_max_d;
      peak_index_q <= peak_index_d;
      peak_freq_q  <= peak_freq_d;
`ifdef CAF_SCHED_TIMEOUT_EN
      error_q      <= error_d;
      wd_q         <= wd_d;
`endif
    end
  end

  assign freq_idx   = freq_idx_q;
  assign peak_max   = peak_max_q;
  assign peak_index = peak_index_q;
  assign peak_freq  = peak_freq_q;
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FINISH);
`ifdef CAF_SCHED_TIMEOUT_EN
  assign error      = error_q;
`else
  assign error      = 1'b0;
`endif

endmodule

// File: tb/tb_caf_peak_sched.sv
// tb_caf_peak_sched
//   Bench for caf_peak_sched: acts as the correlator source and as a
//   behavioural argmax unit (first occurrence of the maximum wins).
//   Expected search results are queued when a search is launched and
//   compared when done pulses.
module tb_caf_peak_sched;

  localparam int unsigned BL     = 10;
  localparam int unsigned NB     = 4;
  localparam int unsigned BUDGET = 2000;

  logic       clk = 1'b0;
  logic       reset, start, src_tvalid, am_s_tready, am_s_tvalid;
  logic [3:0] am_out_max, am_index;
  logic       src_tready, am_m_tvalid, am_m_tready;
  logic [1:0] freq_idx, peak_freq;
  logic [3:0] peak_max, peak_index;
  logic       busy, done, error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  caf_peak_sched #(
    .buffer_length (10),
    .freq_bins     (4),
    .freq_bits     (2),
    .index_bits    (4),
    .out_max_bits  (4),
    .timeout_cycles(64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .src_tvalid (src_tvalid),
    .src_tready (src_tready),
    .am_m_tvalid(am_m_tvalid),
    .am_s_tready(am_s_tready),
    .am_m_tready(am_m_tready),
    .am_s_tvalid(am_s_tvalid),
    .am_out_max (am_out_max),
    .am_index   (am_index),
    .freq_idx   (freq_idx),
    .peak_max   (peak_max),
    .peak_index (peak_index),
    .peak_freq  (peak_freq),
    .busy       (busy),
    .done       (done),
    .error      (error)
  );

  // mx/ix: per-bin peak magnitude and its sample position (bin b in [b]).
  typedef struct {
    logic [3:0][3:0] mx;
    logic [3:0][3:0] ix;
    int unsigned     vprob;
    int unsigned     stall_at;
    int unsigned     dly;
    logic [3:0]      e_max;
    logic [3:0]      e_idx;
    logic [1:0]      e_freq;
  } vec_t;

  typedef struct packed {
    logic [3:0] m;
    logic [3:0] i;
    logic [1:0] f;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [15:0] mx, input logic [15:0] ix,
                              input int unsigned vprob, input int unsigned stall_at,
                              input int unsigned dly, input logic [3:0] em,
                              input logic [3:0] ei, input logic [1:0] ef);
    vec_t v;
    v.mx = mx; v.ix = ix; v.vprob = vprob; v.stall_at = stall_at; v.dly = dly;
    v.e_max = em; v.e_idx = ei; v.e_freq = ef;
    return v;
  endfunction

  // Scoreboard: every done pulse must match the oldest queued search.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done === 1'b1) begin
        chk("done_expected", 32'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("peak_max",   32'(peak_max),   32'(e.m));
          chk("peak_index", 32'(peak_index), 32'(e.i));
          chk("peak_freq",  32'(peak_freq),  32'(e.f));
        end
      end
    end
  end

  // One search: source and argmax model. abort_bin>=0 resets the DUT at
  // beat 5 of that bin; spur_cyc!=0 pulses start while busy.
  task automatic run_search(input vec_t v, input int abort_bin, input int unsigned spur_cyc);
    int unsigned k = 0, mb = 0, dly = 0, total = 0, extra = 0, stall_left = 3, cyc = 0;
    bit waiting = 0, last_cap = 0, got_done = 0;
    logic [3:0] rmax = '0, ridx = '0, smp;
    exp_t e;
    if (abort_bin < 0) begin
      e.m = v.e_max; e.i = v.e_idx; e.f = v.e_freq;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b1;
    while (cyc < BUDGET) begin
      @(negedge clk);
      cyc++;
      if (last_cap) chk("done_latency", 32'(done), 1);
      if (done === 1'b1) begin
        got_done = 1;
        break;
      end
      start       = (cyc == spur_cyc);
      am_s_tvalid = 1'b0;
      if (waiting) begin
        if (dly == 0) begin
          am_s_tvalid = 1'b1;
          am_out_max  = rmax;
          am_index    = ridx;
          waiting     = 0;
          mb++;
          k = 0; stall_left = 3;
          last_cap = (mb == NB);
        end else begin
          dly--;
        end
      end
      src_tvalid  = ($urandom_range(99) < v.vprob);
      am_s_tready = 1'b1;
      if (v.stall_at != 0 && k == v.stall_at && stall_left != 0 && !waiting && mb < NB) begin
        am_s_tready = 1'b0;
        stall_left--;
      end
      #1;
      if (!am_s_tready) chk("stall_src_tready", 32'(src_tready), 0);
      if (src_tvalid && src_tready) begin
        if (waiting || am_s_tvalid || mb >= NB) begin
          extra++;
        end else begin
          chk("freq_idx_stable", 32'(freq_idx), mb);
          smp = (k == 32'(v.ix[mb])) ? v.mx[mb] : 4'd0;
          if (k == 0 || smp > rmax) begin
            rmax = smp;
            ridx = 4'(k);
          end
          k++; total++;
          if (k == BL) begin
            waiting = 1;
            dly = v.dly;
          end
          if (abort_bin >= 0 && mb == 32'(abort_bin) && k == 5) begin
            reset = 1'b1;
            @(negedge clk);
            chk("abort_busy",     32'(busy),     0);
            chk("abort_freq_idx", 32'(freq_idx), 0);
            chk("abort_done",     32'(done),     0);
            chk("abort_peak_max", 32'(peak_max), 0);
            reset = 1'b0;
            src_tvalid = 1'b0;
            start = 1'b0;
            return;
          end
        end
      end
    end
    start = 1'b0; src_tvalid = 1'b0; am_s_tvalid = 1'b0;
    chk("got_done",    32'(got_done), 1);
    chk("bins_done",   mb, NB);
    chk("beats_total", total, NB * BL);
    chk("extra_beats", extra, 0);
    repeat (3) @(negedge clk);
    chk("hold_peak_max", 32'(peak_max), 32'(v.e_max));
    chk("idle_busy",     32'(busy), 0);
    chk("idle_error",    32'(error), 0);
  endtask

  initial begin
    vecs[0] = mk(16'h1934, 16'h0625, 100, 0, 2, 4'd9,  4'd6, 2'd2);
    vecs[1] = mk(16'h7273, 16'h8140, 100, 0, 1, 4'd7,  4'd4, 2'd1);
    vecs[2] = mk(16'h5C32, 16'h9037,  50, 4, 3, 4'd12, 4'd0, 2'd2);
    vecs[3] = mk(16'hF3FF, 16'h1239,  70, 0, 0, 4'd15, 4'd9, 2'd0);
    vecs[4] = mk(16'h0000, 16'h0000, 100, 0, 1, 4'd0,  4'd0, 2'd0);
    vecs[5] = mk(16'h8642, 16'h3579,  60, 6, 2, 4'd8,  4'd3, 2'd3);

    reset = 1'b1; start = 1'b0; src_tvalid = 1'b0; am_s_tready = 1'b1;
    am_s_tvalid = 1'b0; am_out_max = '0; am_index = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy",        32'(busy),        0);
    chk("rst_done",        32'(done),        0);
    chk("rst_error",       32'(error),       0);
    chk("rst_freq_idx",    32'(freq_idx),    0);
    chk("rst_peak_max",    32'(peak_max),    0);
    chk("rst_peak_index",  32'(peak_index),  0);
    chk("rst_peak_freq",   32'(peak_freq),   0);
    chk("rst_src_tready",  32'(src_tready),  0);
    chk("rst_am_m_tready", 32'(am_m_tready), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_search(vecs[i], -1, 0);

    run_search(vecs[0], -1, 15);
    run_search(vecs[1], 1, 0);
    run_search(vecs[1], -1, 0);

`ifdef CAF_SCHED_TIMEOUT_EN
    begin
      int unsigned n = 0;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0; src_tvalid = 1'b1; am_s_tready = 1'b1;
      repeat (10) @(negedge clk);
      src_tvalid = 1'b0;
      while (busy && n < 200) begin
        n++;
        @(negedge clk);
      end
      chk("wd_drain_cycles", n, 64);
      chk("wd_error",        32'(error),    1);
      chk("wd_freq_idx",     32'(freq_idx), 0);
      chk("wd_peak_max",     32'(peak_max), 0);
      repeat (2) @(negedge clk);
      chk("wd_error_sticky", 32'(error), 1);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
      chk("wd_error_clear", 32'(error), 0);
      reset = 1'b1;
      @(negedge clk); reset = 1'b0;
    end
`endif

    repeat (5) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
